// File: rtl/nvm_seq_ctrl.sv
// Access sequencer: serialises CPU fetch/data accesses and programmer writes onto one MRAM port.
// Optional write-verify read-back is enabled by defining NVMIF_WRITE_VERIFY_EN.
module nvm_seq_ctrl #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 32,
  parameter int unsigned WAIT_CYC  = 1,
  parameter logic [31:0] GPIO_ADDR = 32'hFFFF_FFFC,
  parameter int unsigned GPO_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_en,
  input  logic [31:0]        pcnext,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [31:0]        dataadr,
  input  logic [DW-1:0]      writedata,
  input  logic [DW/8-1:0]    wstrb,
  output logic [DW-1:0]      instr,
  output logic [DW-1:0]      readdata,
  output logic               step,
  output logic [AW-1:0]      maddr,
  output logic [DW-1:0]      mwd,
  output logic [DW/8-1:0]    mbe,
  input  logic [DW-1:0]      mrd,
  output logic               we,
  output logic               re,
  output logic [GPO_W-1:0]   gpo,
  input  logic [GPO_W-1:0]   gpi,
  input  logic [AW-1:0]      paddr,
  input  logic [DW-1:0]      pdata,
  input  logic               pwe,
  output logic               prog_busy,
`ifdef NVMIF_WRITE_VERIFY_EN
  output logic               verify_err,
`endif
  output logic               prog_ovf
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYC);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DATA,
    DONE,
    PROG,
    GAP
`ifdef NVMIF_WRITE_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_instr;
  logic [DW-1:0]    r_readdata;
  logic             r_step;
  logic [AW-1:0]    r_maddr;
  logic [DW-1:0]    r_mwd;
  logic [BW-1:0]    r_mbe;
  logic             r_we;
  logic             r_re;
  logic [GPO_W-1:0] r_gpo;
  logic [AW-1:0]    r_paddr;
  logic [DW-1:0]    r_pdata;
  logic             r_prog_busy;
  logic             r_prog_ovf;

  logic w_cnt_last;
  logic w_gpio_hit;
  logic w_data_req;
  logic w_prog_accept;
  logic w_unused;

  assign w_cnt_last    = (r_cnt == CNT_LAST);
  assign w_gpio_hit    = (dataadr == GPIO_ADDR);
  assign w_data_req    = (memread | memwrite) & ~w_gpio_hit;
  assign w_prog_accept = pwe & ~r_prog_busy & (r_state != PROG);
  assign w_unused      = ^{pcnext[31:AW+2], pcnext[1:0]};

`ifdef NVMIF_WRITE_VERIFY_EN
  logic r_vfy_prog;
  logic r_verify_err;
  logic w_vfy_bad;

  // Only bytes that were actually written are compared against the read-back.
  always_comb begin
    w_vfy_bad = 1'b0;
    for (int b = 0; b < BW; b++) begin
      if (r_mbe[b] && (mrd[8*b +: 8] != r_mwd[8*b +: 8])) w_vfy_bad = 1'b1;
    end
  end

  assign verify_err = r_verify_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_instr     <= '0;
      r_readdata  <= '0;
      r_step      <= 1'b0;
      r_maddr     <= '0;
      r_mwd       <= '0;
      r_mbe       <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_gpo       <= '0;
      r_paddr     <= '0;
      r_pdata     <= '0;
      r_prog_busy <= 1'b0;
      r_prog_ovf  <= 1'b0;
`ifdef NVMIF_WRITE_VERIFY_EN
      r_vfy_prog   <= 1'b0;
      r_verify_err <= 1'b0;
`endif
    end else begin
      r_step <= 1'b0;
      if (w_prog_accept) begin
        r_paddr     <= paddr;
        r_pdata     <= pdata;
        r_prog_busy <= 1'b1;
      end else if (pwe) begin
        r_prog_ovf <= 1'b1;
      end

      case (r_state)
        IDLE, DONE: begin
          if (r_prog_busy) begin
            r_state <= PROG;
            r_cnt   <= '0;
            r_we    <= 1'b1;
            r_re    <= 1'b0;
            r_maddr <= r_paddr;
            r_mwd   <= r_pdata;
            r_mbe   <= '1;
          end else if (cpu_en) begin
            r_state <= FETCH;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b1;
            r_maddr <= pcnext[AW+1:2];
          end else begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
          end
        end

        FETCH: begin
          if (w_cnt_last) begin
            r_instr <= mrd;
            r_cnt   <= '0;
            if (w_data_req) begin
              r_state <= DATA;
              r_maddr <= dataadr[AW+1:2];
              if (memwrite) begin
                r_we  <= 1'b1;
                r_re  <= 1'b0;
                r_mwd <= writedata;
                r_mbe <= wstrb;
              end else begin
                r_we  <= 1'b0;
                r_re  <= 1'b1;
                r_mbe <= '1;
              end
            end else begin
              // GPIO accesses complete on entry to DONE so the CPU sees them during step.
              r_state <= DONE;
              r_we    <= 1'b0;
              r_re    <= 1'b0;
              r_step  <= 1'b1;
              if (memwrite && w_gpio_hit) begin
                r_gpo <= writedata[GPO_W-1:0];
              end else if (memread && w_gpio_hit) begin
                r_readdata <= DW'(gpi);
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        DATA: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (!r_we) r_readdata <= mrd;
`ifdef NVMIF_WRITE_VERIFY_EN
            if (r_we) begin
              r_state    <= VERIFY;
              r_we       <= 1'b0;
              r_re       <= 1'b1;
              r_vfy_prog <= 1'b0;
            end else begin
              r_state <= DONE;
              r_we    <= 1'b0;
              r_re    <= 1'b0;
              r_step  <= 1'b1;
            end
`else
            r_state <= DONE;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_step  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        PROG: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            r_we  <= 1'b0;
`ifdef NVMIF_WRITE_VERIFY_EN
            r_state    <= VERIFY;
            r_re       <= 1'b1;
            r_vfy_prog <= 1'b1;
`else
            r_state     <= GAP;
            r_re        <= 1'b0;
            r_prog_busy <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

`ifdef NVMIF_WRITE_VERIFY_EN
        VERIFY: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            r_re  <= 1'b0;
            r_we  <= 1'b0;
            if (w_vfy_bad) r_verify_err <= 1'b1;
            if (r_vfy_prog) begin
              r_state     <= GAP;
              r_prog_busy <= 1'b0;
            end else begin
              r_state <= DONE;
              r_step  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif

        GAP: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_re    <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_re    <= 1'b0;
        end
      endcase
    end
  end

  assign instr     = r_instr;
  assign readdata  = r_readdata;
  assign step      = r_step;
  assign maddr     = r_maddr;
  assign mwd       = r_mwd;
  assign mbe       = r_mbe;
  assign we        = r_we;
  assign re        = r_re;
  assign gpo       = r_gpo;
  assign prog_busy = r_prog_busy;
  assign prog_ovf  = r_prog_ovf;

endmodule
